bht_update_unit: RTL



---
 rtl/bht_update_unit.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/bht_update_unit.sv
// -----------------------------------------------------------------------------
// bht_update_unit
//
// Branch history table (BHT) that sits in the frontend next to PC generation.
// It receives resolved-branch records from the execute-stage branch unit and
// keeps one 2-bit saturating counter per direct-mapped entry. The frontend
// gets a single-cycle taken/not-taken lookup for conditional branches. A
// multi-cycle flush walk invalidates the whole table, one entry per cycle.
//
// Optional build macro: BHT_MISPREDICT_STATS_EN
//   defined   -> 32-bit saturating mispredict counter on mispredict_cnt_o
//   undefined -> no counter register, mispredict_cnt_o tied to 0
//
// Ports:
//   clk_i              clock
//   rst_ni             asynchronous active-low reset
//   flush_i            start (or restart) the full-table invalidation walk
//   vpc_i              lookup PC from the frontend
//   bht_valid_o        lookup hit: indexed entry valid and table not flushing
//   bht_taken_o        predicted taken: counter MSB of a valid entry
//   resolved_branch_i  resolved branch record (branchpredict_t)
//   flush_busy_o       high exactly while the flush walk runs
//   mispredict_cnt_o   mispredict statistics counter
//
// Handshake: the resolved-branch interface has no ready. A record is consumed
// in the cycle its valid is high; it is accepted into the update pipeline only
// when it is a Branch (or carries clear), the table is idle and flush_i is
// low. Otherwise it is dropped silently, so the sender must not rely on
// back-pressure.
// -----------------------------------------------------------------------------

package bht_pkg;

  typedef enum logic [2:0] {
    NoCF,
    Branch,
    Jump,
    JumpR,
    Return
  } cf_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic        is_taken;
    logic        is_mispredict;
    logic        clear;
    cf_t         cf_type;
  } branchpredict_t;

endpackage

module bht_update_unit
  import bht_pkg::*;
#(
  parameter int unsigned NR_ENTRIES = 64
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           flush_i,
  input  logic [63:0]    vpc_i,
  output logic           bht_valid_o,
  output logic           bht_taken_o,
  input  branchpredict_t resolved_branch_i,
  output logic           flush_busy_o,
  output logic [31:0]    mispredict_cnt_o
);

  localparam int unsigned IDX_W = $clog2(NR_ENTRIES);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Snapshot of all control state, kept together so checkers can bind to it.
  typedef struct packed {
    state_t           state;
    logic [IDX_W-1:0] walk;
    logic             upd_pending;
    logic [IDX_W-1:0] upd_idx;
  } bht_dbg_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] walk_q, walk_d;

  // Table storage
  logic             valid_q [NR_ENTRIES];
  logic [1:0]       ctr_q   [NR_ENTRIES];

  // Update register (pipeline stage 1)
  logic             upd_valid_q;
  logic [IDX_W-1:0] upd_idx_q;
  logic             upd_taken_q;
  logic             upd_clear_q;

  logic             accept;
  logic [IDX_W-1:0] rb_idx;
  logic [IDX_W-1:0] lkp_idx;

  logic             cur_valid;
  logic [1:0]       cur_ctr;
  logic             new_valid;
  logic [1:0]       new_ctr;
  logic             upd_we;

  bht_dbg_t         bht_dbg;

  // Bit 0 is dropped so 16-bit compressed instructions index correctly; the
  // upper PC bits are not tagged, so aliasing between PCs is allowed.
  assign rb_idx  = resolved_branch_i.pc[IDX_W:1];
  assign lkp_idx = vpc_i[IDX_W:1];

  // ---------------------------------------------------------------------------
  // Flush FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      walk_q  <= '0;
    end else begin
      state_q <= state_d;
      walk_q  <= walk_d;
    end
  end

  always_comb begin
    state_d = state_q;
    walk_d  = walk_q;
    unique case (state_q)
      IDLE: begin
        if (flush_i) begin
          state_d = FLUSH;
          walk_d  = '0;
        end
      end
      FLUSH: begin
        if (flush_i) begin
          walk_d = '0;
        end else if (&walk_q) begin
          state_d = IDLE;
          walk_d  = '0;
        end else begin
          walk_d = walk_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        walk_d  = '0;
      end
    endcase
  end

  assign flush_busy_o = (state_q == FLUSH);

  // ---------------------------------------------------------------------------
  // Update pipeline, stage 1: capture accepted record
  // ---------------------------------------------------------------------------
  assign accept = resolved_branch_i.valid
                & ((resolved_branch_i.cf_type == Branch) | resolved_branch_i.clear)
                & (state_q == IDLE)
                & ~flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      upd_valid_q <= 1'b0;
      upd_idx_q   <= '0;
      upd_taken_q <= 1'b0;
      upd_clear_q <= 1'b0;
    end else begin
      upd_valid_q <= accept;
      if (accept) begin
        upd_idx_q   <= rb_idx;
        upd_taken_q <= resolved_branch_i.is_taken;
        upd_clear_q <= resolved_branch_i.clear;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Update pipeline, stage 2: read-modify-write of the entry. The array is
  // read here (not in stage 1), so a back-to-back update to the same index
  // sees the value written by its predecessor at the end of the prior cycle.
  // ---------------------------------------------------------------------------
  assign cur_valid = valid_q[upd_idx_q];
  assign cur_ctr   = ctr_q[upd_idx_q];

  always_comb begin
    new_valid = cur_valid;
    new_ctr   = cur_ctr;
    if (upd_clear_q) begin
      new_valid = 1'b0;
      new_ctr   = 2'b01;
    end else if (!cur_valid) begin
      new_valid = 1'b1;
      new_ctr   = upd_taken_q ? 2'b10 : 2'b01;
    end else if (upd_taken_q) begin
      new_ctr   = (cur_ctr == 2'b11) ? 2'b11 : cur_ctr + 2'b01;
    end else begin
      new_ctr   = (cur_ctr == 2'b00) ? 2'b00 : cur_ctr - 2'b01;
    end
  end

  // A pending record is discarded if a flush starts in the same cycle.
  assign upd_we = upd_valid_q & ~flush_i;

  // ---------------------------------------------------------------------------
  // Table storage. The flush walk and a stage-2 write never coincide: the
  // update register only fills while idle, and entering FLUSH discards it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NR_ENTRIES); i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (state_q == FLUSH) begin
      valid_q[walk_q] <= 1'b0;
      ctr_q[walk_q]   <= 2'b01;
    end else if (upd_we) begin
      valid_q[upd_idx_q] <= new_valid;
      ctr_q[upd_idx_q]   <= new_ctr;
    end
  end

  // ---------------------------------------------------------------------------
  // Lookup (combinational)
  // ---------------------------------------------------------------------------
  assign bht_valid_o = valid_q[lkp_idx] & (state_q == IDLE);
  assign bht_taken_o = ctr_q[lkp_idx][1] & bht_valid_o;

  // ---------------------------------------------------------------------------
  // Mispredict statistics
  // ---------------------------------------------------------------------------
`ifdef BHT_MISPREDICT_STATS_EN
  logic [31:0] mis_cnt_q;

  // Counts every valid mispredict regardless of FSM state or cf_type;
  // saturates and is only cleared by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mis_cnt_q <= '0;
    end else if (resolved_branch_i.valid & resolved_branch_i.is_mispredict & ~(&mis_cnt_q)) begin
      mis_cnt_q <= mis_cnt_q + 32'd1;
    end
  end

  assign mispredict_cnt_o = mis_cnt_q;
`else
  assign mispredict_cnt_o = '0;
`endif

  // ---------------------------------------------------------------------------
  // Debug visibility and untagged PC bits
  // ---------------------------------------------------------------------------
  assign bht_dbg = '{
    state:       state_q,
    walk:        walk_q,
    upd_pending: upd_valid_q,
    upd_idx:     upd_idx_q
  };

  logic unused_bits;
  assign unused_bits = ^{vpc_i[63:IDX_W+1], vpc_i[0],
                         resolved_branch_i.pc[63:IDX_W+1], resolved_branch_i.pc[0],
                         resolved_branch_i.is_mispredict, bht_dbg};

endmodule
